// File: rtl/pio_pkg.sv
// Shared register map and edge-select constants for the key/switch input PIO.
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Per-bit edge event from the current and one-cycle-old debounced levels.
    function automatic logic [31:0] pio_edge_event(input logic [31:0] cur,
                                                   input logic [31:0] prev,
                                                   input int unsigned edge_type);
        case (edge_type)
            EDGE_RISING:  return cur & ~prev;
            EDGE_FALLING: return ~cur & prev;
            default:      return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_sync_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-count debouncer.
module pio_sync_debounce
    import pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          RESET_LEVEL     = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic deb_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Any cycle where sync matches deb restarts the count from zero.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CntMax) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= {2{RESET_LEVEL}};
            deb_q  <= RESET_LEVEL;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/pio_key_irq_debounced.sv
// Avalon-MM input PIO: debounced pins, edge capture with W1C and a maskable interrupt.
module pio_key_irq_debounced
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter bit          RESET_LEVEL     = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       address_i,
    input  logic             chipselect_i,
    input  logic             write_n_i,
    input  logic [31:0]      writedata_i,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [31:0]      readdata_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] edge_evt, clr;
    logic [31:0]      evt_full;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_sync_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_sync_debounce (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .pin_i  (in_port_i[i]),
            .deb_o  (deb[i])
        );
    end

    assign unused_wdata = ^writedata_i;
    assign wr           = chipselect_i & ~write_n_i;
    assign evt_full     = pio_edge_event(32'(deb), 32'(deb_prev_q), EDGE_TYPE);
    assign edge_evt     = evt_full[WIDTH-1:0];

    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr && address_i == PIO_ADDR_IRQMASK) begin
            mask_d = writedata_i[WIDTH-1:0];
        end
        if (wr && address_i == PIO_ADDR_EDGECAP) begin
            clr = writedata_i[WIDTH-1:0];
        end
        // A new edge on the same cycle as its clear keeps the bit set.
        cap_d = (cap_q & ~clr) | edge_evt;
        irq_d = |(cap_q & mask_q);
    end

    always_comb begin
        readdata_d = '0;
        unique case (address_i)
            PIO_ADDR_DATA:    readdata_d = 32'(deb);
            PIO_ADDR_DIR:     readdata_d = '0;
            PIO_ADDR_IRQMASK: readdata_d = 32'(mask_q);
            PIO_ADDR_EDGECAP: readdata_d = 32'(cap_q);
            default:          readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            deb_prev_q <= {WIDTH{RESET_LEVEL}};
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata_o = readdata_q;
    assign irq_o      = irq_q;

endmodule
